// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for the 8-bit sync FIFO, feeding a valid/ready stream framed in BURST_LEN bursts.
// Define FIFO_RD_PARITY_EN to add the m_parity output (XOR of the head byte).
module fifo_stream_reader #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd_en,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic          m_parity
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_head, r_tail, w_head_d;
  logic            r_head_last, r_tail_last, w_head_last_d;
  logic [1:0]      r_occ, w_occ_nxt;
  logic            r_infl;
  logic [7:0]      r_cnt;
  logic            w_pop, w_cap, w_cap_last, w_head_we, w_tail_we;
  logic [2:0]      w_lvl;
  assign w_pop      = m_valid & m_ready;
  assign w_cap      = r_infl;
  assign w_cap_last = r_cnt == 8'(BURST_LEN - 1);
  assign w_lvl      = {1'b0, r_occ} + {2'b0, r_infl} - {2'b0, w_pop};
  assign fifo_rd_en = (r_state == RUN) & ~fifo_empty & (w_lvl < 3'd2);
  assign w_occ_nxt  = r_occ + {1'b0, w_cap} - {1'b0, w_pop};
  assign m_valid    = r_occ != 2'd0;
  assign m_data     = r_head;
  assign m_last     = r_head_last;
  assign busy       = r_state != IDLE;
  // A pop from a full buffer promotes the tail; otherwise the head takes the captured byte.
  assign w_head_we     = w_pop | ((r_occ == 2'd0) & w_cap);
  assign w_head_d      = (w_pop & (r_occ == 2'd2)) ? r_tail : fifo_data;
  assign w_head_last_d = (w_pop & (r_occ == 2'd2)) ? r_tail_last : w_cap_last;
  assign w_tail_we     = w_cap & (((r_occ == 2'd1) & ~w_pop) | ((r_occ == 2'd2) & w_pop));
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = enable ? RUN : IDLE;
      RUN:     w_state_nxt = enable ? RUN : STOP;
      STOP:    w_state_nxt = enable ? RUN : (!r_infl && w_occ_nxt == 2'd0) ? IDLE : STOP;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_head_last <= 1'b0;
      r_tail_last <= 1'b0;
      r_occ       <= 2'd0;
      r_infl      <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
      r_infl  <= fifo_rd_en;
      if (w_cap) r_cnt <= w_cap_last ? 8'd0 : r_cnt + 8'd1;
      if (w_head_we) begin
        r_head      <= w_head_d;
        r_head_last <= w_head_last_d;
      end
      if (w_tail_we) begin
        r_tail      <= fifo_data;
        r_tail_last <= w_cap_last;
      end
    end
  end
`ifdef FIFO_RD_PARITY_EN
  logic r_head_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_head_par <= 1'b0;
    else if (w_head_we) r_head_par <= ^w_head_d;
  end
  assign m_parity = r_head_par;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with a behavioural 1-cycle-latency FIFO feeding the reader.
module tb_fifo_stream_reader;
  localparam int BL = 16;
  logic clk = 0, rst_n = 0, enable = 0, m_ready = 0;
  logic fifo_empty = 1;
  logic [7:0] fifo_data = 0, m_data;
  logic fifo_rd_en, m_valid, m_last, busy;
`ifdef FIFO_RD_PARITY_EN
  logic m_parity;
`endif
  logic [7:0] fq[$], exp_q[$];
  int n_chk = 0, n_err = 0, tb_cnt = 0, n_last = 0;
  logic stall_q = 0;
  logic [7:0] stall_d = 0;

  fifo_stream_reader #(.DW(8), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy)
`ifdef FIFO_RD_PARITY_EN
    , .m_parity(m_parity)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 0;
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_data <= fq.pop_front();
      fifo_empty <= fq.size() == 0;
    end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("no_underflow", fifo_rd_en & fifo_empty, 0);
      if (stall_q) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_d);
      end
`ifdef FIFO_RD_PARITY_EN
      if (m_valid) chk("parity", m_parity, ^m_data);
`endif
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious", 1, 0);
        else begin
          chk("data", m_data, exp_q.pop_front());
          chk("last", m_last, tb_cnt == BL - 1);
          tb_cnt = (tb_cnt == BL - 1) ? 0 : tb_cnt + 1;
          n_last += int'(m_last);
        end
      end
      stall_q = m_valid && !m_ready;
      stall_d = m_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nl0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst_n = 1;
    // preloaded 3-byte transfer and read latency
    @(negedge clk);
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    enable = 1; m_ready = 1;
    #2 chk("t1_idle_rd", fifo_rd_en, 0);
    @(negedge clk); #2;
    chk("t1_rd_c0", fifo_rd_en, 1);
    chk("t1_v_c0", m_valid, 0);
    @(negedge clk); #2;
    chk("t1_v_c1", m_valid, 0);
    @(negedge clk); #2;
    chk("t1_v_c2", m_valid, 1);
    chk("t1_d_c2", m_data, 8'h11);
    @(negedge clk); #2;
    chk("t1_d_c3", m_data, 8'h22);
    chk("t1_rd_c3", fifo_rd_en, 0);
    @(negedge clk); #2;
    chk("t1_d_c4", m_data, 8'h33);
    chk("t1_rd_c4", fifo_rd_en, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk); #2;
    chk("t1_v_end", m_valid, 0);
    // asynchronous reset mid-burst
    @(negedge clk);
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 50 && exp_q.size() > 5; i++) begin
      @(negedge clk);
      #2;
    end
    chk("t5_progress", exp_q.size() <= 5, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_rd", fifo_rd_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_last", m_last, 0);
    fq.delete(); exp_q.delete(); fifo_empty = 1; tb_cnt = 0; stall_q = 0;
    #2 rst_n = 1;
    @(negedge clk);
    nl0 = n_last;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    drain(60, "t5_drain");
    chk("t5_lasts", n_last - nl0, 1);
    // 40 back-to-back bytes
    @(negedge clk);
    nl0 = n_last;
    for (int i = 0; i < 40; i++) push(8'(i * 7 + 1));
    for (int i = 0; i < 10 && !m_valid; i++) begin
      @(negedge clk);
      #2;
    end
    for (int i = 0; i < 40; i++) begin
      chk("t2_b2b", m_valid, 1);
      @(negedge clk);
      #2;
    end
    drain(20, "t2_drain");
    chk("t2_lasts", n_last - nl0, 2);
    // m_ready toggling every cycle
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'hC0 ^ 8'(i * 13));
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      m_ready = ~m_ready;
    end
    drain(10, "t3_drain");
    // enable dropped with one read in flight and one byte buffered
    @(negedge clk);
    m_ready = 0;
    @(negedge clk);
    push(8'hA1); push(8'hA2); push(8'hA3);
    #2 chk("t4_rd_k0", fifo_rd_en, 1);
    @(negedge clk); #2;
    chk("t4_rd_k1", fifo_rd_en, 1);
    @(negedge clk);
    enable = 0;
    #2;
    chk("t4_rd_k2", fifo_rd_en, 0);
    chk("t4_d_k2", m_data, 8'hA1);
    @(negedge clk);
    m_ready = 1;
    #2;
    chk("t4_rd_k3", fifo_rd_en, 0);
    chk("t4_busy_k3", busy, 1);
    @(negedge clk); #2;
    chk("t4_d_k4", m_data, 8'hA2);
    chk("t4_busy_k4", busy, 1);
    chk("t4_rd_k4", fifo_rd_en, 0);
    @(negedge clk); #2;
    chk("t4_busy_k5", busy, 0);
    chk("t4_v_k5", m_valid, 0);
    chk("t4_rd_k5", fifo_rd_en, 0);
    @(negedge clk); #2;
    chk("t4_rd_k6", fifo_rd_en, 0);
    chk("t4_left", exp_q.size(), 1);
    enable = 1;
    drain(10, "t4_drain");
`ifdef FIFO_RD_PARITY_EN
    @(negedge clk);
    m_ready = 0;
    push(8'h03); push(8'h07);
    for (int i = 0; i < 10 && !m_valid; i++) begin
      @(negedge clk);
      #2;
    end
    chk("t6_d0", m_data, 8'h03);
    chk("t6_p0", m_parity, 0);
    @(negedge clk);
    m_ready = 1;
    @(negedge clk); #2;
    chk("t6_d1", m_data, 8'h07);
    chk("t6_p1", m_parity, 1);
    drain(10, "t6_drain");
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team's 8-bit synchronous FIFO (`wr_en`/`rd_en`/`data_in`/`data_out`/`full`/`empty`).
- Pops bytes when the FIFO is non-empty, absorbs the FIFO's 1-cycle read latency, and presents bytes on a valid/ready stream.
- Sustains 1 byte/cycle under continuous `m_ready`.
- Frames output into bursts of BURST_LEN bytes, flagged by `m_last`.

Parameters:
- DW, 8, data width; matches the FIFO `data_out`.
- BURST_LEN, 16, bytes per burst; `m_last` is asserted on the final byte of each burst; range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset; all state cleared immediately while low.
- enable  input  1  run request; level sensitive.
- fifo_empty  input  1  FIFO `empty` flag.
- fifo_data  input  DW  FIFO `data_out`; valid the cycle after `fifo_rd_en`.
- fifo_rd_en  output  1  FIFO pop strobe; combinational.
- m_valid  output  1  output byte valid.
- m_data  output  DW  output byte.
- m_last  output  1  final byte of current burst; qualified by `m_valid`.
- m_ready  input  1  downstream accept.
- busy  output  1  high in RUN or STOP.

Behaviour:
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `fifo_rd_en`=0, state=IDLE, burst count=0, buffer occupancy=0, in-flight=0.
- Internal storage:
  - 2-entry holding buffer (head/tail registers) with `occ` 0..2.
  - `infl` flag: a read was issued last cycle.
  - `m_data`/`m_valid` always reflect the buffer head.
- `pop` = `m_valid` & `m_ready`.
- `fifo_rd_en` = (state==RUN) & !`fifo_empty` & (`occ` + `infl` - `pop` < 2).
  - Never asserted while `fifo_empty`=1; no underflow possible.
- Latency: `fifo_rd_en` at cycle N → `fifo_data` sampled at the end of N+1 → `m_valid`=1 in N+2 if the buffer was empty.
- Simultaneous capture and pop: the captured byte enters at the correct slot; order is preserved strictly FIFO.
- `m_valid`/`m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- Burst counter:
  - Counts popped bytes, 0..BURST_LEN-1.
  - `m_last` = head byte is at count BURST_LEN-1; it is tagged at capture and stored per entry.
  - Counter wraps to 0 after the `m_last` pop.
  - BURST_LEN=1 gives `m_last` on every byte.
- FSM:
  - IDLE: `enable`=1 → RUN.
  - RUN: `enable`=0 → STOP.
  - STOP:
    - No new reads are issued.
    - In-flight reads complete and buffered bytes are still delivered.
    - When `infl`=0 and `occ`=0 → IDLE.
    - `enable`=1 in STOP → RUN directly.
  - The burst counter is NOT cleared by stop/start; only reset clears it.
- `busy` = (state != IDLE).
- FIFO goes empty mid-burst: reads pause, `m_valid` drops after the buffer drains, and the burst count is retained.
- `rst_n` low mid-transfer: buffered and in-flight bytes are discarded, outputs return to reset values asynchronously, and `fifo_rd_en` drops immediately.

Optional Feature:
- FIFO_RD_PARITY_EN:
  - When defined, adds output `m_parity` (1 bit): even parity (XOR) of the head byte, registered alongside `m_data`, reset 0.
  - When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then `enable`=1 with FIFO preloaded 0x11,0x22,0x33 and `m_ready`=1 → first `fifo_rd_en` in cycle 0, `m_valid` from cycle 2, bytes 0x11,0x22,0x33 on consecutive cycles, `fifo_rd_en` low once `fifo_empty`=1.
- FIFO holds 40 bytes, BURST_LEN=16, `m_ready`=1 → 40 back-to-back bytes, `m_last` on bytes 16 and 32 only, burst count=8 at end.
- `m_ready` toggling 1/0 every cycle with 8 bytes queued → no byte lost or duplicated, `m_data` stable while stalled, `occ` never exceeds 2, `fifo_rd_en` never high when `fifo_empty`.
- `enable` dropped with one read in flight and 1 byte buffered → both bytes delivered, `busy` falls the cycle after the last pop, no further `fifo_rd_en`.
- `rst_n` pulsed low for 3 ns mid-burst → `m_valid`, `fifo_rd_en`, `busy` go 0 asynchronously; after release the next burst restarts with count 0.
- FIFO_RD_PARITY_EN defined, bytes 0x03 then 0x07 → `m_parity`=0 then 1.
